fetch_stage: RTL and testbench

//  Instruction fetch stage directly upstream of the decoder: owns the PC, issues word fetches
//  to instruction memory over a valid/ready request + fixed-order response bus, buffers returned

---
 rtl/fetch_stage.sv | 199 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues word fetches, buffers responses and feeds decode.
// Latency: request -> response (memory) -> id_valid one cycle after the response is written.
// Backpressure: credit-limited requests (FIFO + outstanding <= FIFO_DEPTH); responses are never stalled.
// Optional feature macro: PAUSE_HALT_EN (stop fetching after decode pops a PAUSE instruction).

// Small synchronous FIFO with flush; storage resets to zero so the head reads 0 out of reset.
// Latency: a write is visible at rd_dat/count the cycle after it is accepted.
// Backpressure: caller must not write when full unless it pops in the same cycle.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_ok;
    logic          wr_ok;

    assign rd_ok  = rd_rdy && (count != '0) && !flush;
    assign wr_ok  = wr_vld && ((count != FULL_CNT) || rd_ok) && !flush;
    assign rd_dat = mem_q[rd_ptr];

    // Storage: written at the tail on an accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_ptr] <= wr_dat;
        end
    end

    // Pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end
endmodule

// Fetch stage top: PC, request credit, PC shadow queue, instruction buffer, redirect handling.
// Latency: id_valid rises one cycle after the response carrying the word.
// Backpressure: id_ready low fills the buffer, which withholds request credit; rsp never stalls.
module fetch_stage #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            halted
);
    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_W    = (CW+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0]   pc_q;
    logic              run_q;
    logic [CW-1:0]     drop_cnt_q;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     outstanding;
    logic [XLEN-1:0]   rsp_pc;
    logic [2*XLEN-1:0] head_dat;
    logic              credit_ok;
    logic              req_fire;
    logic              id_fire;
    logic              rsp_drop;
    logic              fifo_push;

    // Every issued request must have a guaranteed buffer slot for its response
    assign credit_ok      = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_W;
    assign imem_req_valid = run_q && !halted && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses belonging to the pre-redirect stream are discarded
    assign rsp_drop  = redirect_valid || (drop_cnt_q != '0);
    assign fifo_push = imem_rsp_valid && !rsp_drop;

    assign id_valid = (fifo_count != '0) && !redirect_valid;
    assign id_fire  = id_valid && id_ready;
    assign id_instr = head_dat[2*XLEN-1:XLEN];
    assign id_pc    = head_dat[XLEN-1:0];

    // PC register; run_q keeps requests off until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid) begin
                pc_q <= redirect_pc & ALIGN_MASK;
            end else if (req_fire) begin
                pc_q <= pc_q + PC_STEP;
            end
        end
    end

    // Count of in-flight responses still owed to an abandoned stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (redirect_valid) begin
            drop_cnt_q <= outstanding - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_q <= drop_cnt_q - CW'(1);
        end
    end

    // Issued PCs wait here until their in-order response returns; its depth is the outstanding count
    fetch_fifo #(
        .W     (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_shadow (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (1'b0),
        .wr_vld (req_fire),
        .wr_dat (pc_q),
        .rd_rdy (imem_rsp_valid),
        .rd_dat (rsp_pc),
        .count  (outstanding)
    );

    // Instruction buffer holding {instr, pc} pairs for decode
    fetch_fifo #(
        .W     (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (redirect_valid),
        .wr_vld (fifo_push),
        .wr_dat ({imem_rsp_data, rsp_pc}),
        .rd_rdy (id_fire),
        .rd_dat (head_dat),
        .count  (fifo_count)
    );

`ifdef PAUSE_HALT_EN
    localparam logic [6:0] OPC_PAUSE = 7'b0001111;
    logic halted_q;

    // Halt after decode consumes a PAUSE; only a redirect restarts fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (id_fire && (id_instr[6:0] == OPC_PAUSE)) begin
            halted_q <= 1'b1;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with an epoch-based stream model and an in-order memory model.
// Latency: memory responds 1+lat cycles after a request; checks sampled 1 time unit after negedge.
// Backpressure: req_ready / id_ready / rsp timing driven randomly or by directed knobs.
module tb_fetch_stage;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    // Reference model: memory queue of issued fetches, delivered-stream queue, fetch PC, epoch
    mreq_t       memq[$];
    logic [31:0] mfifo[$];
    int          epoch;
    logic [31:0] exp_pc;
    logic        exp_halted;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int rdy_pct, idr_pct, rsp_pct, lat_max, redir_pm;
    bit rsp_hold, force_redir, pause_mode;
    logic [31:0] force_pc;

    logic [31:0] popped[$];
    logic [31:0] req_addrs[$];
    int req_cnt, pop_cnt;
    bit obs_req_vld, obs_id_vld, obs_halted, obs_req_fire;
    logic [31:0] obs_req_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        if (pause_mode && a == 32'h8) return 32'h0000_000F;
        return {h[31:7], 7'b0110011};
    endfunction

    task automatic set_knobs(input int rdy, input int idr, input int rsp, input int lat, input int rpm);
        rdy_pct = rdy; idr_pct = idr; rsp_pct = rsp; lat_max = lat; redir_pm = rpm;
        rsp_hold = 1'b0; force_redir = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        memq.delete(); mfifo.delete();
        epoch = 0; exp_pc = RESET_PC; exp_halted = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req_vld", 32'(imem_req_valid), 32'h0);
        check_eq("rst_id_vld", 32'(id_valid), 32'h0);
        check_eq("rst_id_instr", id_instr, 32'h0);
        check_eq("rst_id_pc", id_pc, 32'h0);
        check_eq("rst_halted", 32'(halted), 32'h0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model past posedge
    task automatic step();
        bit mrf, midf, rd, exp_req_vld, exp_id_vld;
        logic [31:0] hd;
        mreq_t m;
        @(negedge clk);
        imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
        id_ready       = ($urandom_range(0, 99) < idr_pct);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
        end else begin
            redirect_valid = ($urandom_range(0, 999) < redir_pm);
            redirect_pc    = $urandom;
        end
        if (!rsp_hold && memq.size() > 0 && memq[0].due <= cyc && $urandom_range(0, 99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        rd          = redirect_valid;
        exp_req_vld = !exp_halted && !rd && (mfifo.size() + memq.size() < DEPTH);
        exp_id_vld  = (mfifo.size() > 0) && !rd;
        check_eq("req_vld", 32'(imem_req_valid), 32'(exp_req_vld));
        check_eq("req_addr", imem_req_addr, exp_pc);
        check_eq("id_vld", 32'(id_valid), 32'(exp_id_vld));
        if (exp_id_vld) begin
            check_eq("id_pc", id_pc, mfifo[0]);
            check_eq("id_instr", id_instr, memfn(mfifo[0]));
        end
        check_eq("halted", 32'(halted), 32'(exp_halted));

        obs_req_vld  = imem_req_valid;
        obs_req_addr = imem_req_addr;
        obs_id_vld   = id_valid;
        obs_halted   = halted;
        obs_req_fire = imem_req_valid && imem_req_ready;
        if (obs_req_fire) begin
            req_addrs.push_back(imem_req_addr);
            req_cnt++;
        end
        if (id_valid && id_ready) begin
            popped.push_back(id_pc);
            pop_cnt++;
        end

        mrf  = exp_req_vld && imem_req_ready;
        midf = exp_id_vld && id_ready;
        if (imem_rsp_valid) begin
            m = memq.pop_front();
            if (!rd && m.epoch == epoch) mfifo.push_back(m.addr);
        end
        if (midf) begin
            hd = mfifo.pop_front();
`ifdef PAUSE_HALT_EN
            begin
                logic [31:0] ins;
                ins = memfn(hd);
                if (ins[6:0] == 7'b0001111) exp_halted = 1'b1;
            end
`endif
        end
        if (mrf) begin
            m.addr = exp_pc; m.epoch = epoch; m.due = cyc + 1 + $urandom_range(0, lat_max);
            memq.push_back(m);
            exp_pc = exp_pc + 32'd4;
        end
        if (rd) begin
            epoch++;
            mfifo.delete();
            exp_pc     = redirect_pc & 32'hFFFF_FFFC;
            exp_halted = 1'b0;
        end
        force_redir = 1'b0;
        cyc++;
    endtask

    initial begin
        int first_req, first_vld;
        bit found;
        pause_mode = 1'b0;
        set_knobs(100, 100, 100, 0, 0);

        // 1: sequential fetch, first id_valid two cycles after the first request
        apply_reset();
        first_req = -1; first_vld = -1; pop_cnt = 0; popped.delete();
        for (int i = 0; i < 30; i++) begin
            step();
            if (first_req < 0 && obs_req_fire) first_req = cyc - 1;
            if (first_vld < 0 && obs_id_vld) first_vld = cyc - 1;
        end
        check_eq("t1_id_vld_latency", 32'(first_vld - first_req), 32'd2);
        check_eq("t1_first_pc", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h0);
        check_eq("t1_progress", 32'(pop_cnt >= 15), 32'h1);

        // 2: decode stalled -> only FIFO_DEPTH requests, then resume in order
        apply_reset();
        set_knobs(100, 0, 100, 0, 0);
        req_cnt = 0; popped.delete();
        repeat (8) step();
        check_eq("t2_req_cnt", 32'(req_cnt), 32'd2);
        check_eq("t2_req_vld_low", 32'(obs_req_vld), 32'h0);
        idr_pct = 100;
        for (int i = 0; i < 20 && popped.size() < 3; i++) step();
        check_eq("t2_pop0", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h0);
        check_eq("t2_pop1", (popped.size() > 1) ? popped[1] : 32'hDEAD_BEEF, 32'h4);
        check_eq("t2_pop2", (popped.size() > 2) ? popped[2] : 32'hDEAD_BEEF, 32'h8);

        // 3: redirect with two responses in flight drops both
        apply_reset();
        set_knobs(100, 100, 100, 0, 0);
        rsp_hold = 1'b1;
        force_redir = 1'b1; force_pc = 32'h10;
        step();
        req_addrs.delete();
        repeat (3) step();
        check_eq("t3_inflight0", (req_addrs.size() > 0) ? req_addrs[0] : 32'hDEAD_BEEF, 32'h10);
        check_eq("t3_inflight1", (req_addrs.size() > 1) ? req_addrs[1] : 32'hDEAD_BEEF, 32'h14);
        force_redir = 1'b1; force_pc = 32'h100;
        step();
        rsp_hold = 1'b0;
        popped.delete(); req_addrs.delete();
        for (int i = 0; i < 20 && popped.size() < 2; i++) step();
        check_eq("t3_next_req", (req_addrs.size() > 0) ? req_addrs[0] : 32'hDEAD_BEEF, 32'h100);
        check_eq("t3_first_id_pc", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h100);
        check_eq("t3_second_id_pc", (popped.size() > 1) ? popped[1] : 32'hDEAD_BEEF, 32'h104);

        // 4: redirect coinciding with a response and a pending decode handshake; misaligned target
        apply_reset();
        set_knobs(100, 0, 100, 0, 0);
        repeat (2) step();
        idr_pct = 100;
        force_redir = 1'b1; force_pc = 32'h203;
        pop_cnt = 0;
        step();
        check_eq("t4_id_vld_redirect", 32'(obs_id_vld), 32'h0);
        check_eq("t4_no_pop", 32'(pop_cnt), 32'h0);
        step();
        check_eq("t4_fifo_empty", 32'(obs_id_vld), 32'h0);
        check_eq("t4_pc_target", obs_req_addr, 32'h200);
        popped.delete();
        for (int i = 0; i < 10 && popped.size() < 1; i++) step();
        check_eq("t4_first_id_pc", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h200);

        // 5: PAUSE at pc 0x8
        apply_reset();
        set_knobs(100, 100, 100, 0, 0);
        pause_mode = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            popped.delete();
            step();
            if (popped.size() > 0 && popped[0] == 32'h8) found = 1'b1;
        end
        check_eq("t5_pause_popped", 32'(found), 32'h1);
        repeat (6) step();
`ifdef PAUSE_HALT_EN
        check_eq("t5_halted", 32'(obs_halted), 32'h1);
        check_eq("t5_req_blocked", 32'(obs_req_vld), 32'h0);
        force_redir = 1'b1; force_pc = 32'h40;
        step();
        req_addrs.delete();
        repeat (3) step();
        check_eq("t5_unhalted", 32'(obs_halted), 32'h0);
        check_eq("t5_resume_addr", (req_addrs.size() > 0) ? req_addrs[0] : 32'hDEAD_BEEF, 32'h40);
`else
        check_eq("t5_not_halted", 32'(obs_halted), 32'h0);
        check_eq("t5_fetch_continues", 32'(obs_req_addr > 32'h10), 32'h1);
`endif
        pause_mode = 1'b0;

        // 6: asynchronous reset with the buffer full
        apply_reset();
        set_knobs(100, 0, 100, 0, 0);
        repeat (6) step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_req_vld", 32'(imem_req_valid), 32'h0);
        check_eq("t6_id_vld", 32'(id_valid), 32'h0);
        check_eq("t6_id_instr", id_instr, 32'h0);
        check_eq("t6_id_pc", id_pc, 32'h0);
        check_eq("t6_req_addr", imem_req_addr, RESET_PC);
        apply_reset();
        set_knobs(100, 100, 100, 0, 0);
        req_addrs.delete();
        repeat (4) step();
        check_eq("t6_restart_addr", (req_addrs.size() > 0) ? req_addrs[0] : 32'hDEAD_BEEF, RESET_PC);

        // Random phase: mixed backpressure, latency and redirects
        apply_reset();
        set_knobs(70, 70, 70, 3, 30);
        pop_cnt = 0;
        repeat (3000) step();
        check_eq("rand_progress", 32'(pop_cnt > 200), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
